motor_drive_sequencer: RTL

- Safety sequencer between the motor decision logic and the external relay H-bridge module.
- Takes raw per-motor direction requests and emits relay drive lines MIN11/MIN21 (motor 1) and MIN12/MIN22 (motor 2).
- Enforces minimum on-time, mandatory dead-time on every drive exit, a global enable gate driven by the mode FSM (Defense|Attack), and illegal-request fault capture.
- Two identical independent channels share one clock and reset.

---
 rtl/motor_drive_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_drive_sequencer.sv
// ---------------------------------------------------------------------------
// motor_drive_sequencer
//
// Purpose:
//   Safety sequencer that sits between the motor decision logic and the
//   external relay H-bridge. It turns raw per-motor direction requests into
//   the relay drive lines, and it enforces four rules on each motor:
//     - a minimum on-time for every drive state,
//     - a fixed dead-time (both lines low) on every exit from a drive state,
//     - a global enable gate,
//     - a sticky flag that captures illegal requests.
//   The two motor channels are identical and run independently. They share
//   only the clock, the reset, the enable and the fault-clear pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   global drive enable; low forces every channel to stop
//   req1[1:0]  in   motor 1 request {in1,in2}: 10 fwd, 01 rev, 00 coast,
//                   11 illegal
//   req2[1:0]  in   motor 2 request, same encoding as req1
//   fault_clr  in   single-cycle pulse that clears both fault flags
//   MIN11      out  motor 1 relay input 1 (forward), registered
//   MIN21      out  motor 1 relay input 2 (reverse), registered
//   MIN12      out  motor 2 relay input 1 (forward), registered
//   MIN22      out  motor 2 relay input 2 (reverse), registered
//   busy1      out  motor 1 channel is in its dead-time
//   busy2      out  motor 2 channel is in its dead-time
//   fault1     out  sticky flag: illegal request seen on req1
//   fault2     out  sticky flag: illegal request seen on req2
// ---------------------------------------------------------------------------

// One motor channel: the drive-state FSM, its cycle counter and its fault flag.
module motor_drive_channel #(
    parameter int unsigned DEAD_CYC = 4,
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       fault_clr_i,
    output logic       fwd_o,
    output logic       rev_o,
    output logic       busy_o,
    output logic       fault_o
);

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // The counter value seen on the last allowed cycle of each timed phase.
    localparam logic [CNT_W-1:0] MinOnLast = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MinOnSat  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] DeadLast  = CNT_W'(DEAD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fwd_q, rev_q, busy_q, fault_q;
    logic             fault_d;
    logic             illegal, forceStop, effFwd, effRev, holdDir;

    // An illegal request or a low enable both count as coast. They also
    // override the minimum on-time, so a drive state is dropped at once.
    always_comb begin
        illegal   = (req_i == 2'b11);
        forceStop = !en_i || illegal;
        effFwd    = !forceStop && (req_i == 2'b10);
        effRev    = !forceStop && (req_i == 2'b01);
    end

    // Next-state logic. FWD and REV can only be left through DEAD, and DEAD
    // always runs for its full length, whatever the enable does.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        holdDir = 1'b0;
        unique case (state_q)
            ST_COAST: begin
                if (effFwd) begin
                    state_d = ST_FWD;
                    cnt_d   = '0;
                end else if (effRev) begin
                    state_d = ST_REV;
                    cnt_d   = '0;
                end
            end
            ST_FWD, ST_REV: begin
                holdDir = (state_q == ST_FWD) ? effFwd : effRev;
                cnt_d   = (cnt_q >= MinOnSat) ? cnt_q : cnt_q + CNT_W'(1);
                if (!holdDir && (forceStop || cnt_q >= MinOnLast)) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end
            end
            ST_DEAD: begin
                if (cnt_q >= DeadLast) begin
                    cnt_d = '0;
                    if (effFwd) begin
                        state_d = ST_FWD;
                    end else if (effRev) begin
                        state_d = ST_REV;
                    end else begin
                        state_d = ST_COAST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_COAST;
                cnt_d   = '0;
            end
        endcase
    end

    // A new illegal request takes priority over a clear pulse in the same cycle.
    always_comb begin
        fault_d = illegal || (fault_q && !fault_clr_i);
    end

    // The outputs are decoded from the next state and registered. They then
    // change on the same edge as the state, and the relay lines stay glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_COAST;
            cnt_q   <= '0;
            fwd_q   <= 1'b0;
            rev_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_q   <= (state_d == ST_FWD);
            rev_q   <= (state_d == ST_REV);
            busy_q  <= (state_d == ST_DEAD);
            fault_q <= fault_d;
        end
    end

    assign fwd_o   = fwd_q;
    assign rev_o   = rev_q;
    assign busy_o  = busy_q;
    assign fault_o = fault_q;

endmodule

// Top level: two independent channels that share the enable and the fault clear.
module motor_drive_sequencer #(
    parameter int unsigned DEAD_CYC = 4,
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req1,
    input  logic [1:0] req2,
    input  logic       fault_clr,
    output logic       MIN11,
    output logic       MIN21,
    output logic       MIN12,
    output logic       MIN22,
    output logic       busy1,
    output logic       busy2,
    output logic       fault1,
    output logic       fault2
);

    motor_drive_channel #(
        .DEAD_CYC (DEAD_CYC),
        .MIN_ON   (MIN_ON),
        .CNT_W    (CNT_W)
    ) u_ch1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .req_i       (req1),
        .fault_clr_i (fault_clr),
        .fwd_o       (MIN11),
        .rev_o       (MIN21),
        .busy_o      (busy1),
        .fault_o     (fault1)
    );

    motor_drive_channel #(
        .DEAD_CYC (DEAD_CYC),
        .MIN_ON   (MIN_ON),
        .CNT_W    (CNT_W)
    ) u_ch2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .req_i       (req2),
        .fault_clr_i (fault_clr),
        .fwd_o       (MIN12),
        .rev_o       (MIN22),
        .busy_o      (busy2),
        .fault_o     (fault2)
    );

endmodule
